seven_segment_scan_controller: RTL and testbench
================================================

# seven_segment_scan_controller

Time-multiplexed driver for an N-digit seven-segment display that shares one BCD-to-segment decoder across all digits. It holds a double-buffered BCD word, scans the digits one at a time with a programmable dwell time and an anti-ghosting blank gap, and optionally suppresses leading zeros. It sits between the numeric datapath, which produces packed BCD, and the board display pins.

## Interface
- NUM_DIGITS, 4: number of digits. Must be at least 2.
- DWELL_CYCLES, 50000: clocks each digit is lit. Must be at least 1.
- BLANK_CYCLES, 2: clocks with all anodes off between digits. 0 removes the gap.
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous and active-high.
- enable  in  1  scan enable. Low forces the display dark.
- lz_suppress  in  1  leading-zero suppression enable.
- load_valid  in  1  a new display word is offered.
- load_ready  out  1  pending buffer is empty; the word is accepted when load_valid and load_ready are both high.
- load_data  in  4*NUM_DIGITS  packed BCD. Nibble 0 (bits [3:0]) is the rightmost, least significant digit.
- seg  out  7  segment drive {a,b,c,d,e,f,g}, with a at bit 6. Active-high.
- an  out  NUM_DIGITS  digit enable, one-hot or zero. Active-high. Bit i lights digit i.
- frame_done  out  1  one-cycle pulse when the last digit's slot ends.

## Operation
- Registers:
  - pending: NUM_DIGITS nibbles plus pending_full.
  - display: NUM_DIGITS nibbles.
  - digit index idx.
  - dwell/blank counter cnt.
  - FSM state.
- FSM states: IDLE, SHOW, BLANK.
  - IDLE: an=0, seg=0, idx=0, cnt=0. Goes to SHOW when enable=1.
  - SHOW: an has only bit idx set; seg = decode(display[idx]) unless that digit is suppressed. After DWELL_CYCLES clocks, goes to BLANK, or advances directly when BLANK_CYCLES=0.
  - BLANK: an=0, seg=0 for BLANK_CYCLES clocks, then idx advances and the FSM returns to SHOW.
  - Index wrap: idx goes NUM_DIGITS-1 -> 0. The frame_done pulse fires on the cycle of the wrap.
- enable=0 in any state: IDLE on the next clock, and the current frame is abandoned.
- Load handshake:
  - load_ready = !pending_full.
  - On accept, pending captures load_data and pending_full sets.
  - While full, load_ready=0 and further offers stall.
- Transfer pending -> display happens only at a frame boundary (the wrap cycle) or on any IDLE cycle, and clears pending_full. This prevents tearing within a frame.
  - Simultaneous transfer and offer: the offer is not accepted that cycle (load_ready=0); it is accepted the following cycle.
- Decode table:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011.
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Codes 10-15 produce 0000000.
- Leading-zero suppression: when lz_suppress=1, digit i>0 is suppressed if display[i] and all more significant nibbles are 0.
  - A suppressed digit gives seg=0000000, but its an bit still follows the scan so the duty cycle is unchanged.
  - Digit 0 is never suppressed.

## Timing
- seg, an and frame_done are registered. State changes on edge k are visible after edge k.
- enable rising while IDLE: the first SHOW cycle is lit (an=1<<0) on the next edge.
- Digit period is DWELL_CYCLES+BLANK_CYCLES clocks. Frame period is NUM_DIGITS times that.
- Load-to-visible latency is at most one frame plus 1 clock when enabled, and 1 clock when IDLE.
- Counter width is clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1). cnt saturates nowhere; it is cleared on every state change.
- Reset values, applied immediately and independent of clk:
  - State and data: state=IDLE, idx=0, cnt=0, display=0, pending=0, pending_full=0.
  - Outputs: seg=0, an=0, frame_done=0, load_ready=1.
- Reset mid-frame aborts the frame with no partial transfer.

## Structure
- Package seg7_pkg holds:
  - the state enum (IDLE, SHOW, BLANK);
  - the constant SEG_BLANK=7'b0000000;
  - the ten segment patterns as named constants.
- One sub-module: seg7_decoder, a combinational 4-bit in / 7-bit out decoder using the table above. It is instantiated once, fed from the display nibble mux.
- The top level contains the FSM, counter, double buffer, zero-suppression chain and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=1.
- Load 16'h1234 in IDLE, then enable.
  - Digit 0: an=0001, seg=0110011 for 4 clocks.
  - Then an=0000 for 1 clock.
  - Then digit 1: an=0010, seg=1111001.
  - Sequence continues to digit 3 showing 1 (0110000).
- lz_suppress=1 with word 16'h0070: digits 3 and 2 give seg=0000000 with their an bits still active; digit 1 shows 1110000; digit 0 shows 1111110. Word 16'h0000: only digit 0 is lit (1111110).
- Double buffer:
  - Load 16'h1111 during digit 1 of a 16'h1234 frame: digits 2 and 3 still show 2 and 1; digit 0 shows 1 only after the frame_done pulse.
  - A second offer while pending is full sees load_ready=0 until the wrap.
- Drop enable during digit 2: after the next edge, an=0 and seg=0. Re-enable: the scan restarts at digit 0 with the full 4-clock dwell.
- Assert rst mid-SHOW without a clock edge: an, seg and frame_done go to 0 immediately, and load_ready=1. After release, display reads 0.
- Word 16'hA000 with lz_suppress=0: digit 3 gives seg=0000000 while an=1000. frame_done pulses once every 20 clocks.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: FSM encoding and
// segment patterns in {a,b,c,d,e,f,g} order, active-high.
package seg7_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHOW  = 2'd1;
  localparam state_t ST_BLANK = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD-to-segment decoder; non-decimal codes render dark.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed N-digit seven-segment driver with a double-buffered BCD
// word, dwell/blank scan timing and optional leading-zero suppression.
module seven_segment_scan_controller
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    lz_suppress,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int DATA_W  = 4 * NUM_DIGITS;
  localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]       pending_q, pending_d;
  logic                    pending_full_q, pending_full_d;
  logic [DATA_W-1:0]       display_q, display_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic                    wrap;
  logic                    transfer;
  logic                    accept;
  logic                    all_zero;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_nibble;
  logic [6:0]              dec_seg;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    wrap    = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SHOW;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d = '0;
            if (BLANK_CYCLES == 0) begin
              wrap  = (idx_q == IDX_LAST);
              idx_d = wrap ? '0 : idx_q + IDX_W'(1);
            end else begin
              state_d = ST_BLANK;
            end
          end
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            state_d = ST_SHOW;
            wrap    = (idx_q == IDX_LAST);
            idx_d   = wrap ? '0 : idx_q + IDX_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Display only changes between frames (or while dark) so a word never tears.
  always_comb begin
    transfer       = pending_full_q && ((state_q == ST_IDLE) || wrap);
    accept         = load_valid && !pending_full_q;
    pending_d      = accept ? load_data : pending_q;
    display_d      = transfer ? pending_q : display_q;
    pending_full_d = accept ? 1'b1 : (transfer ? 1'b0 : pending_full_q);
  end

  always_comb begin
    lz_blank   = '0;
    all_zero   = 1'b1;
    cur_nibble = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero    = all_zero && (display_d[4*i +: 4] == 4'd0);
      lz_blank[i] = lz_suppress && (i != 0) && all_zero;
      if (idx_d == IDX_W'(i)) cur_nibble = display_d[4*i +: 4];
    end
  end

  seg7_decoder u_decoder (
    .bcd (cur_nibble),
    .seg (dec_seg)
  );

  // Outputs are registered from next-state values so they track the FSM edge-for-edge.
  always_comb begin
    an_d         = '0;
    seg_d        = SEG_BLANK;
    frame_done_d = wrap;
    if (state_d == ST_SHOW) begin
      an_d = NUM_DIGITS'(1) << idx_d;
      if (!lz_blank[idx_d]) seg_d = dec_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      display_q      <= '0;
      seg_q          <= SEG_BLANK;
      an_q           <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      display_q      <= display_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
  assign load_ready = !pending_full_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a time-based model of the scan (digit = position / slot).
module tb_seven_segment_scan_controller;

  localparam int NDIG  = 4;
  localparam int DWELL = 4;
  localparam int BLANK = 1;
  localparam int SLOT  = DWELL + BLANK;
  localparam int FRAME = NDIG * SLOT;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        lz_suppress;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int n_cmp;
  int n_fail;

  // Model state: whether scanning, cycles since the scan started, buffers.
  bit          m_run;
  int          m_tick;
  bit          m_wrap;
  bit          m_full;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic [6:0]  seg_tab [16];

  seven_segment_scan_controller #(
    .NUM_DIGITS   (NDIG),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .lz_suppress (lz_suppress),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .seg         (seg),
    .an          (an),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_tick = 0;
    m_wrap = 1'b0;
    m_full = 1'b0;
    m_disp = '0;
    m_pend = '0;
  endtask

  task automatic model_edge(input logic en, input logic lv, input logic [15:0] data);
    bit was_idle;
    bit xfer;
    bit acc;
    was_idle = !m_run;
    m_wrap   = 1'b0;
    if (!en) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      m_run  = 1'b1;
      m_tick = 0;
    end else begin
      m_tick++;
      m_wrap = (m_tick % FRAME) == 0;
    end
    xfer = m_full && (was_idle || m_wrap);
    acc  = lv && !m_full;
    if (xfer) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end
    if (acc) begin
      m_pend = data;
      m_full = 1'b1;
    end
  endtask

  task automatic model_outputs(input logic lz);
    int p;
    int d;
    logic [3:0] nib;
    exp_an  = '0;
    exp_seg = '0;
    if (m_run) begin
      p = m_tick % FRAME;
      d = p / SLOT;
      if (p % SLOT < DWELL) begin
        exp_an = 4'(1 << d);
        nib    = 4'((m_disp >> (4 * d)) & 16'hF);
        if (!(lz && d > 0 && (m_disp >> (4 * d)) == 16'h0)) exp_seg = seg_tab[nib];
      end
    end
  endtask

  task automatic applyStimulus(input logic en, input logic lz, input logic lv, input logic [15:0] data);
    enable      = en;
    lz_suppress = lz;
    load_valid  = lv;
    load_data   = data;
    model_edge(en, lv, data);
    model_outputs(lz);
    @(posedge clk);
    #1;
    checkOutput("an", 32'(an), 32'(exp_an));
    checkOutput("seg", 32'(seg), 32'(exp_seg));
    checkOutput("frame_done", 32'(frame_done), 32'(m_wrap));
    checkOutput("load_ready", 32'(load_ready), 32'(!m_full));
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    int nz;
    w = '0;
    for (int i = 0; i < NDIG; i++)
      w[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    nz = $urandom_range(0, NDIG);
    for (int i = 0; i < nz; i++) w[4*(NDIG-1-i) +: 4] = 4'd0;
    return w;
  endfunction

  initial begin
    int fd_count;
    logic en_r;
    logic lz_r;
    n_cmp  = 0;
    n_fail = 0;
    seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
                7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    rst         = 1'b1;
    enable      = 1'b0;
    lz_suppress = 1'b0;
    load_valid  = 1'b0;
    load_data   = '0;
    model_reset();

    #2;
    checkOutput("reset_an", 32'(an), 32'h0);
    checkOutput("reset_seg", 32'(seg), 32'h0);
    checkOutput("reset_frame_done", 32'(frame_done), 32'h0);
    checkOutput("reset_load_ready", 32'(load_ready), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Load 1234 while idle, then scan one full frame.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234);
    checkOutput("idle_load_ready_low", 32'(load_ready), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("first_an", 32'(an), 32'h1);
    checkOutput("first_seg", 32'(seg), 32'(7'b0110011));
    for (int i = 1; i < FRAME; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      if (i == 4) checkOutput("gap_an", 32'(an), 32'h0);
      if (i == 5) checkOutput("digit1_seg", 32'(seg), 32'(7'b1111001));
      if (i == 15) checkOutput("digit3_seg", 32'(seg), 32'(7'b0110000));
    end

    // Double buffer: new word during digit 1 waits for the frame boundary.
    for (int t = 20; t <= 25; t++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h1111);
    checkOutput("db_accept_ready", 32'(load_ready), 32'h0);
    for (int t = 27; t <= 41; t++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h5678);
      if (t == 30) checkOutput("db_digit2_old", 32'(seg), 32'(7'b1101101));
      if (t == 35) checkOutput("db_stall_ready", 32'(load_ready), 32'h0);
      if (t == 40) checkOutput("db_wrap_pulse", 32'(frame_done), 32'h1);
      if (t == 40) checkOutput("db_digit0_new", 32'(seg), 32'(7'b0110000));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);

    // Drop enable during digit 2, then restart from digit 0.
    for (int t = 43; t <= 51; t++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("drop_an", 32'(an), 32'h0);
    checkOutput("drop_seg", 32'(seg), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("restart_seg", 32'(seg), 32'(7'b1111111));
    for (int i = 1; i <= DWELL; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      if (i < DWELL) checkOutput("restart_dwell_an", 32'(an), 32'h1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);

    // Asynchronous reset in the middle of digit 1.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_an", 32'(an), 32'h0);
    checkOutput("async_seg", 32'(seg), 32'h0);
    checkOutput("async_frame_done", 32'(frame_done), 32'h0);
    checkOutput("async_load_ready", 32'(load_ready), 32'h1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("post_reset_seg", 32'(seg), 32'(7'b1111110));

    // Leading-zero suppression: 0070 then 0000.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0070);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < FRAME; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      if (i == 5) checkOutput("lz_digit1", 32'(seg), 32'(7'b1110000));
      if (i == 10) checkOutput("lz_digit2_an", 32'(an), 32'h4);
      if (i == 10) checkOutput("lz_digit2_seg", 32'(seg), 32'h0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < FRAME; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      if (i == 0) checkOutput("lz_zero_digit0", 32'(seg), 32'(7'b1111110));
      if (i == 5) checkOutput("lz_zero_digit1", 32'(seg), 32'h0);
    end

    // Non-decimal code A renders dark; frame_done period.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hA000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    fd_count = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      fd_count += int'(frame_done);
      if (i == 15) checkOutput("hexA_an", 32'(an), 32'h8);
      if (i == 15) checkOutput("hexA_seg", 32'(seg), 32'h0);
    end
    checkOutput("frame_done_count", 32'(fd_count), 32'd2);

    // Random traffic against the model.
    lz_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      en_r = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 15) == 0) lz_r = ~lz_r;
      applyStimulus(en_r, lz_r, ($urandom_range(0, 3) == 0), rand_word());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
